// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter slice.
// Requester count, select/burst widths and the FSM state encoding.
package mux_arb_pkg;

    localparam int N_REQ  = 8;
    localparam int SEL_W  = 3;
    localparam int BCNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(
        input logic [SEL_W-1:0] i
    );
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8to1.sv
// Shared 8:1 single-bit data mux, steered by the arbiter select.
module mux8to1
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] d,
    input  logic [SEL_W-1:0] s,
    output logic             y
);

    assign y = d[s];

endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first set req bit scanning ptr, ptr+1, ...
// Pure combinational; found is low when no request is pending.
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the far end so the position closest to ptr wins last.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin 8-way arbiter with burst limit steering a shared 8:1 mux.
// Releases on owner drop or after MAX_BURST accepted transfers.
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    input  logic             ready,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             dout,
    output logic             dvalid,
    output logic             busy
);

    state_t            state;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  sel_q;
    logic [BCNT_W-1:0] bcnt;
    logic [N_REQ-1:0]  gnt_q;

    logic              owner_req;
    logic              xfer;
    logic              last;
    logic              rel;
    logic [SEL_W-1:0]  pick_ptr;
    logic [SEL_W-1:0]  pick_idx;
    logic              found;

    assign owner_req = req[sel_q];
    assign busy      = (state == GRANT);
    assign dvalid    = busy && owner_req;
    assign xfer      = dvalid && ready;
    assign last      = (bcnt == BCNT_W'(MAX_BURST - 1));
    assign rel       = busy && (!owner_req || (xfer && last));

    // On release the pointer moves past the owner in the same cycle.
    assign pick_ptr  = busy ? sel_q + SEL_W'(1) : ptr;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (found),
        .idx   (pick_idx)
    );

    mux8to1 u_mux (
        .d (din),
        .s (sel_q),
        .y (dout)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            sel_q <= '0;
            bcnt  <= '0;
            gnt_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        gnt_q <= onehot(pick_idx);
                        sel_q <= pick_idx;
                        bcnt  <= '0;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        ptr <= sel_q + SEL_W'(1);
                        if (found) begin
                            gnt_q <= onehot(pick_idx);
                            sel_q <= pick_idx;
                            bcnt  <= '0;
                        end else begin
                            state <= IDLE;
                            gnt_q <= '0;
                        end
                    end else if (xfer) begin
                        bcnt <= bcnt + BCNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= '0;
                end
            endcase
        end
    end

    assign gnt = gnt_q;
    assign sel = sel_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: vector table, directed corners, random vs model.
// Three instances (burst limits 4, 2, 1) share one stimulus stream.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic [7:0] din;
    logic       ready;

    logic [7:0] gnt_w    [3];
    logic [2:0] sel_w    [3];
    logic       dout_w   [3];
    logic       dvalid_w [3];
    logic       busy_w   [3];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req(req), .din(din), .ready(ready),
        .gnt(gnt_w[0]), .sel(sel_w[0]), .dout(dout_w[0]),
        .dvalid(dvalid_w[0]), .busy(busy_w[0])
    );

    mux8_rr_arbiter #(.MAX_BURST(2)) dut2 (
        .clk(clk), .reset(reset), .req(req), .din(din), .ready(ready),
        .gnt(gnt_w[1]), .sel(sel_w[1]), .dout(dout_w[1]),
        .dvalid(dvalid_w[1]), .busy(busy_w[1])
    );

    mux8_rr_arbiter #(.MAX_BURST(1)) dut3 (
        .clk(clk), .reset(reset), .req(req), .din(din), .ready(ready),
        .gnt(gnt_w[2]), .sel(sel_w[2]), .dout(dout_w[2]),
        .dvalid(dvalid_w[2]), .busy(busy_w[2])
    );

    // Reference model: owner / pointer / transfers-this-grant per instance
    bit m_busy [3];
    int m_sel  [3];
    int m_ptr  [3];
    int m_cnt  [3];

    function automatic int mbof(input int m);
        return (m == 0) ? 4 : (m == 1) ? 2 : 1;
    endfunction

    function automatic int find(input int p, input logic [7:0] r);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    task automatic model_reset(input int m);
        m_busy[m] = 0; m_sel[m] = 0; m_ptr[m] = 0; m_cnt[m] = 0;
    endtask

    task automatic advance(input int m);
        int  j;
        bit  up;
        bit  moved;
        if (!reset) begin
            model_reset(m);
        end else if (!m_busy[m]) begin
            j = find(m_ptr[m], req);
            if (j >= 0) begin
                m_busy[m] = 1; m_sel[m] = j; m_cnt[m] = 0;
            end
        end else begin
            up    = req[m_sel[m]];
            moved = up && ready;
            if (!up || (moved && m_cnt[m] + 1 == mbof(m))) begin
                m_ptr[m] = (m_sel[m] + 1) % 8;
                j = find(m_ptr[m], req);
                if (j >= 0) begin
                    m_sel[m] = j; m_cnt[m] = 0;
                end else begin
                    m_busy[m] = 0;
                end
            end else if (moved) begin
                m_cnt[m]++;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
    endtask

    task automatic check_model(input int m);
        logic [7:0] g;
        g = '0;
        if (m_busy[m]) g[m_sel[m]] = 1'b1;
        chk($sformatf("m%0d gnt", m), 32'(gnt_w[m]), 32'(g));
        chk($sformatf("m%0d sel", m), 32'(sel_w[m]), m_sel[m]);
        chk($sformatf("m%0d busy", m), 32'(busy_w[m]), 32'(m_busy[m]));
        chk($sformatf("m%0d dvalid", m), 32'(dvalid_w[m]),
            32'(m_busy[m] && req[m_sel[m]]));
        chk($sformatf("m%0d dout", m), 32'(dout_w[m]), 32'(din[m_sel[m]]));
    endtask

    // Drive one cycle: settle, compare against model, clock, advance model
    task automatic cyc(input logic rs, input logic [7:0] r,
                       input logic [7:0] d, input logic rd);
        reset = rs; req = r; din = d; ready = rd;
        #1;
        for (int m = 0; m < 3; m++) check_model(m);
        @(posedge clk);
        for (int m = 0; m < 3; m++) advance(m);
        #1;
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] r;
        logic       rd;
        logic [7:0] eg;
        logic [2:0] es;
        logic       eb;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [7:0] d;
        bit         rs;
        logic [7:0] r;

        // Row: inputs, then gnt/sel/busy of the burst-4 instance after the edge
        tbl[0]  = '{1'b0, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 8'hFF, 1'b1, 8'h01, 3'd0, 1'b1};
        tbl[3]  = '{1'b0, 8'h81, 1'b1, 8'h00, 3'd0, 1'b0};
        tbl[4]  = '{1'b1, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1};
        tbl[5]  = '{1'b1, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1};
        tbl[6]  = '{1'b1, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1};
        tbl[7]  = '{1'b1, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1};
        tbl[8]  = '{1'b1, 8'h81, 1'b1, 8'h80, 3'd7, 1'b1};
        tbl[9]  = '{1'b1, 8'h81, 1'b1, 8'h80, 3'd7, 1'b1};
        tbl[10] = '{1'b1, 8'h81, 1'b1, 8'h80, 3'd7, 1'b1};
        tbl[11] = '{1'b1, 8'h81, 1'b1, 8'h80, 3'd7, 1'b1};
        tbl[12] = '{1'b1, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1};

        reset = 1'b0; req = '0; din = '0; ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        for (int m = 0; m < 3; m++) model_reset(m);
        #1;

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].rs, tbl[i].r, 8'($urandom), tbl[i].rd);
            chk($sformatf("vec%0d gnt", i), 32'(gnt_w[0]), 32'(tbl[i].eg));
            chk($sformatf("vec%0d sel", i), 32'(sel_w[0]), 32'(tbl[i].es));
            chk($sformatf("vec%0d busy", i), 32'(busy_w[0]), 32'(tbl[i].eb));
        end

        // Lone requester 3, burst 2: continuous grant, count 0,1,0,1...
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 8'h08, 8'($urandom), 1'b1);
            chk("solo gnt", 32'(gnt_w[1]), 32'h08);
            chk("solo bcnt", 32'(dut2.bcnt), 32'(k % 2));
            chk("solo dvalid", 32'(dvalid_w[1]), 32'h1);
        end

        // Owner 5 stalled by ready low: grant and count hold, dout follows din[5]
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        cyc(1'b1, 8'h20, 8'h00, 1'b0);
        d = '0;
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            cyc(1'b1, 8'h20, d, 1'b0);
            chk("stall gnt", 32'(gnt_w[0]), 32'h20);
            chk("stall bcnt", 32'(dut.bcnt), 32'h0);
            chk("stall dout", 32'(dout_w[0]), 32'(d[5]));
        end
        cyc(1'b1, 8'h20, d, 1'b1);
        chk("stall resume bcnt", 32'(dut.bcnt), 32'h1);

        // Owner 2 drops after one transfer; 6 takes over with no gap
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        cyc(1'b1, 8'h44, 8'($urandom), 1'b1);
        chk("drop gnt2", 32'(gnt_w[0]), 32'h04);
        cyc(1'b1, 8'h44, 8'($urandom), 1'b1);
        reset = 1'b1; req = 8'h40; ready = 1'b1;
        #1;
        chk("drop dvalid", 32'(dvalid_w[0]), 32'h0);
        cyc(1'b1, 8'h40, 8'($urandom), 1'b1);
        chk("drop gnt6", 32'(gnt_w[0]), 32'h40);

        // Reset mid-burst of owner 4, then arbitration restarts at 0
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        cyc(1'b1, 8'h10, 8'($urandom), 1'b1);
        chk("rst4 gnt", 32'(gnt_w[0]), 32'h10);
        cyc(1'b1, 8'h10, 8'($urandom), 1'b1);
        cyc(1'b0, 8'h10, 8'($urandom), 1'b1);
        chk("rst4 gnt0", 32'(gnt_w[0]), 32'h00);
        chk("rst4 busy0", 32'(busy_w[0]), 32'h0);
        chk("rst4 sel0", 32'(sel_w[0]), 32'h0);
        cyc(1'b1, 8'hFF, 8'($urandom), 1'b1);
        chk("rst4 restart", 32'(gnt_w[0]), 32'h01);

        // Random traffic against the model for all three burst limits
        for (int n = 0; n < 3000; n++) begin
            rs = ($urandom % 64) != 0;
            case ($urandom % 4)
                0: r = 8'($urandom) & 8'($urandom);
                1: r = 8'($urandom);
                2: r = 8'h01 << ($urandom % 8);
                default: r = 8'($urandom) | 8'($urandom);
            endcase
            cyc(rs, r, 8'($urandom), ($urandom % 4) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 4, meaning maximum accepted transfers per grant (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port req, input, 8 bits, per-requester request; bit i belongs to requester i.
REQ-005 The block SHALL have port din, input, 8 bits, per-requester data bit; din[i] belongs to requester i.
REQ-006 The block SHALL have port ready, input, 1 bit, downstream accepts dout this cycle.
REQ-007 The block SHALL have port gnt, output, 8 bits, one-hot grant, or all-zero when idle.
REQ-008 The block SHALL have port sel, output, 3 bits, index of the current or last owner, driving the shared 8:1 mux select.
REQ-009 The block SHALL have port dout, output, 1 bit, equal to din[sel], combinational.
REQ-010 The block SHALL have port dvalid, output, 1 bit, dout carries owner data this cycle.
REQ-011 The block SHALL have port busy, output, 1 bit, high when the state is GRANT.

Function
REQ-012 The state machine SHALL have exactly two states, IDLE and GRANT, plus a 3-bit priority pointer ptr and a burst counter bcnt of width 4.
REQ-013 Arbitration SHALL pick the first set req bit scanning ptr, ptr+1, ... mod 8.
REQ-014 In IDLE, if any req bit is high, the next edge SHALL enter GRANT, set gnt to the one-hot of the picked index, set sel to that index and set bcnt to 0; request-to-grant latency is 1 cycle.
REQ-015 In IDLE with req==0, the state SHALL remain IDLE, gnt SHALL be 0 and sel SHALL hold its value.
REQ-016 dvalid SHALL equal (state==GRANT) && req[sel]; a transfer occurs on any cycle with dvalid && ready.
REQ-017 On each transfer, bcnt SHALL increment by 1.
REQ-018 The release condition SHALL be rel = !req[sel] || (dvalid && ready && bcnt==MAX_BURST-1).
REQ-019 On rel in GRANT, ptr SHALL become sel+1 mod 8 (wrap 7->0), and arbitration SHALL run in the same cycle using the new ptr.
REQ-020 On rel, if a requester is found, the next edge SHALL grant it directly, with no idle gap and bcnt=0; otherwise the next edge SHALL enter IDLE with gnt=0.
REQ-021 A burst-limited owner that is the only requester SHALL be regranted immediately, since it has lowest priority after ptr advance.
REQ-022 With MAX_BURST=1, the block SHALL rearbitrate after every transfer.
REQ-023 While ready is low, bcnt SHALL hold and the grant SHALL persist indefinitely while req[sel] stays high.
REQ-024 Requests arriving or dropping on non-owner bits during GRANT SHALL have no effect until the next rel.
REQ-025 gnt SHALL never have more than one bit set, and gnt[sel] SHALL be 1 whenever busy is high.

Reset
REQ-026 While reset is low at a rising edge, the block SHALL set state=IDLE, gnt=0, sel=0, ptr=0 and bcnt=0; dvalid, busy SHALL be 0 and dout SHALL equal din[0].
REQ-027 Reset asserted mid-burst SHALL abort the grant at that edge, with no transfer counted, and arbitration SHALL restart from ptr=0 after release.

Structure
REQ-028 Shared package mux_arb_pkg SHALL hold N_REQ=8, SEL_W=3, BCNT_W=4 and the state enumeration IDLE/GRANT.
REQ-029 The rotating priority pick SHALL be the one sub-module rr_pick8 (req[7:0], ptr[2:0] -> found, idx[2:0]).
REQ-030 dout SHALL be produced by the existing mux8to1 instance driven by sel.

Verification
REQ-031 The bench SHALL cover reset low for 2 cycles with req=8'hFF, then release -> gnt=0 during reset, next edge gnt=8'h01, sel=0.
REQ-032 The bench SHALL cover req=8'h81, ready=1, MAX_BURST=4 -> requester 0 owns for 4 transfers, then gnt=8'h80 next cycle with no gap, then back to 8'h01 (ptr wrap 7->0).
REQ-033 The bench SHALL cover a single requester 3 held, ready=1, MAX_BURST=2 -> gnt stays 8'h08 continuously, bcnt cycles 0,1,0,1, and dvalid is constantly 1.
REQ-034 The bench SHALL cover owner 5 with ready=0 for 10 cycles then 1 -> gnt=8'h20 held, no bcnt change, and dout tracks din[5].
REQ-035 The bench SHALL cover owner 2 dropping req after 1 transfer while req[6] is high -> dvalid=0 that cycle, next edge gnt=8'h40.
REQ-036 The bench SHALL cover reset pulsed low mid-burst of owner 4 -> next edge gnt=0, busy=0, ptr=0.
